// File: rtl/counter_checker.sv
// counter_checker
//   On-chip monitor for an N-bit up/down counter with synchronous clear,
//   parallel load and enable. It taps the same control stimulus as the
//   counter and runs a cycle-accurate reference model. Every disagreement
//   between the model and the counter output is flagged. The block also
//   keeps an error count, a sticky error flag and a capture of the first
//   failure for LEDs or a debug readout.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset; clears everything
//   resync     : one-cycle pulse; realigns the model to the observed q
//   syn_clr    : counter control inputs, exactly as the counter sees them
//   load, en   :
//   up, d      :
//   q          : counter output under check
//   max_tick   : counter flags under check (used only with TICK_CHECK_EN)
//   min_tick   :
//   synced     : model is aligned and comparing (CHECK or HALT)
//   mismatch   : one-cycle pulse, one cycle after a failed comparison
//   err        : sticky error flag
//   err_cnt    : failed comparisons, saturating
//   chk_cnt    : comparisons performed, saturating
//   first_exp  : expected q at the first failure
//   first_got  : observed q at the first failure
//
// Build option
//   TICK_CHECK_EN : when defined, max_tick/min_tick are also compared
//                   against the model value.
module counter_checker #(
  parameter int N           = 3,
  parameter int ERR_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resync,
  input  logic             syn_clr,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [N-1:0]     d,
  input  logic [N-1:0]     q,
  input  logic             max_tick,
  input  logic             min_tick,
  output logic             synced,
  output logic             mismatch,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] chk_cnt,
  output logic [N-1:0]     first_exp,
  output logic [N-1:0]     first_got
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_CHECK  = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  localparam logic [N-1:0]     Q_ZERO   = {N{1'b0}};
  localparam logic [N-1:0]     Q_ONE    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     Q_MAX    = {N{1'b1}};
  localparam logic [ERR_W-1:0] CNT_ZERO = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] CNT_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] CNT_MAX  = {ERR_W{1'b1}};

  state_t           r_state;
  logic [N-1:0]     r_exp_q;
  logic             r_synced;
  logic             r_mismatch;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] r_chk_cnt;
  logic [N-1:0]     r_first_exp;
  logic [N-1:0]     r_first_got;

  logic [N-1:0]     w_f_q;
  logic [N-1:0]     w_f_exp;
  logic             w_fail;

  // Counter next-state rule: clear beats load beats count; arithmetic wraps.
  function automatic logic [N-1:0] next_val(
    input logic [N-1:0] x,
    input logic         clr,
    input logic         ld,
    input logic         cen,
    input logic         cup,
    input logic [N-1:0] dd
  );
    logic [N-1:0] nxt;
    if (clr) begin
      nxt = Q_ZERO;
    end else if (ld) begin
      nxt = dd;
    end else if (cen && cup) begin
      nxt = x + Q_ONE;
    end else if (cen) begin
      nxt = x - Q_ONE;
    end else begin
      nxt = x;
    end
    return nxt;
  endfunction

  // Saturating increment for the statistics counters.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == CNT_MAX) ? c : (c + CNT_ONE);
  endfunction

  // Model successors: from observed q when aligning, from itself when tracking.
  always_comb begin
    w_f_q   = next_val(q, syn_clr, load, en, up, d);
    w_f_exp = next_val(r_exp_q, syn_clr, load, en, up, d);
  end

  // One pass/fail verdict per edge; flag disagreements fold into the same verdict.
  always_comb begin
    w_fail = (q != r_exp_q);
`ifdef TICK_CHECK_EN
    if ((max_tick != (r_exp_q == Q_MAX)) || (min_tick != (r_exp_q == Q_ZERO))) begin
      w_fail = 1'b1;
    end else begin
      w_fail = (q != r_exp_q);
    end
`endif
  end

`ifndef TICK_CHECK_EN
  logic w_unused_ticks;
  assign w_unused_ticks = max_tick | min_tick;
`endif

  // Checker FSM with reference model, statistics and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_UNSYNC;
      r_exp_q     <= Q_ZERO;
      r_synced    <= 1'b0;
      r_mismatch  <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= CNT_ZERO;
      r_chk_cnt   <= CNT_ZERO;
      r_first_exp <= Q_ZERO;
      r_first_got <= Q_ZERO;
    end else if (resync) begin
      // Statistics survive a resync; only the alignment is dropped.
      r_state    <= ST_UNSYNC;
      r_synced   <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      case (r_state)
        ST_UNSYNC: begin
          // Seed from the observed counter so its own reset timing is irrelevant.
          r_exp_q    <= w_f_q;
          r_state    <= ST_CHECK;
          r_synced   <= 1'b1;
          r_mismatch <= 1'b0;
        end
        ST_CHECK: begin
          // Model follows itself, never q, so one glitch cannot mask later ones.
          r_exp_q   <= w_f_exp;
          r_chk_cnt <= sat_inc(r_chk_cnt);
          if (w_fail) begin
            r_mismatch <= 1'b1;
            r_err      <= 1'b1;
            r_err_cnt  <= sat_inc(r_err_cnt);
            if (!r_err) begin
              r_first_exp <= r_exp_q;
              r_first_got <= q;
            end
            if (STOP_ON_ERR) begin
              r_state <= ST_HALT;
            end
          end else begin
            r_mismatch <= 1'b0;
          end
        end
        ST_HALT: begin
          r_mismatch <= 1'b0;
        end
        default: begin
          r_state    <= ST_UNSYNC;
          r_synced   <= 1'b0;
          r_mismatch <= 1'b0;
        end
      endcase
    end
  end

  assign synced    = r_synced;
  assign mismatch  = r_mismatch;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign chk_cnt   = r_chk_cnt;
  assign first_exp = r_first_exp;
  assign first_got = r_first_got;

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Synthesizable on-chip monitor placed directly downstream of the enhanced binary counter.
- Taps the same control stimulus the counter receives (syn_clr, load, en, up, d) plus the counter outputs (q, max_tick, min_tick).
- Runs a cycle-accurate reference model and flags every mismatch.
- Supplies error count, sticky error flag and first-failure capture for LEDs or a debug readout in the counter monitor experiment.

Parameters:
- N, 3, counter width in bits; must equal the counter's N.
- ERR_W, 8, width of the error and check counters; both saturate.
- STOP_ON_ERR, 0, 1 = enter HALT on the first mismatch and freeze all statistics.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- resync  input  1  single-cycle pulse; re-aligns the model to the observed q (leaves UNSYNC via a fresh alignment).
- syn_clr  input  1  counter synchronous clear, as presented to the counter.
- load  input  1  counter parallel load.
- en  input  1  counter enable.
- up  input  1  count direction: 1 = up, 0 = down.
- d  input  N  counter load data.
- q  input  N  counter output under check.
- max_tick  input  1  counter max flag under check.
- min_tick  input  1  counter min flag under check.
- synced  output  1  model aligned and comparing (state CHECK or HALT).
- mismatch  output  1  registered one-cycle pulse for a failed comparison.
- err  output  1  sticky error flag.
- err_cnt  output  ERR_W  number of failed comparisons; saturates at all-ones.
- chk_cnt  output  ERR_W  number of comparisons performed; saturates.
- first_exp  output  N  expected q at the first failure.
- first_got  output  N  observed q at the first failure.

Behaviour:
- Reference next-state f(x), evaluated in priority order:
  - syn_clr = 1 -> 0.
  - else load = 1 -> d.
  - else en = 1 and up = 1 -> x+1 mod 2^N (2^N-1 wraps to 0).
  - else en = 1 and up = 0 -> x-1 mod 2^N (0 wraps to 2^N-1).
  - else -> x.
- Reset (rst = 1 at a rising edge): state UNSYNC, exp_q = 0, synced = 0, mismatch = 0, err = 0, err_cnt = 0, chk_cnt = 0, first_exp = 0, first_got = 0.
- UNSYNC:
  - No comparison is made.
  - exp_q <= f(q) using the current inputs.
  - Next state CHECK.
  - Needs exactly one clean cycle after reset; this tolerates the counter's own asynchronous reset.
- CHECK, each edge:
  - Compare q against exp_q.
  - chk_cnt increments.
  - exp_q <= f(exp_q). The model always follows its own value, never q, so one error does not mask later errors.
- On a failed comparison:
  - mismatch = 1 for exactly the following cycle (one-cycle latency from the sampled q).
  - err set.
  - err_cnt increments.
  - If err was 0 before this edge, first_exp <= exp_q and first_got <= q; later failures do not overwrite them.
  - If STOP_ON_ERR = 1, next state HALT.
- HALT: all counters, flags and first_* hold; mismatch = 0; exits only on rst or resync.
- resync in any state:
  - Next state UNSYNC.
  - err, err_cnt, chk_cnt and first_* are preserved; only rst clears statistics.
  - resync and rst in the same cycle: rst wins.
- Counter saturation: at all-ones an increment leaves the value unchanged, and the mismatch pulse still fires.
- Mid-operation rst: all outputs return to reset values at that edge; no pulse leaks into the following cycle.

Optional Feature:
- Macro: TICK_CHECK_EN.
- Defined:
  - Also compare max_tick against (exp_q == 2^N-1) and min_tick against (exp_q == 0) in the same cycle as q.
  - Any of the three failing counts as one failure (a single err_cnt increment).
  - first_got still captures q only.
- Undefined: max_tick and min_tick are ignored; no related logic is generated.

Test Plan:
- N=3. rst, 1 idle cycle, en=1 up=1 for 10 cycles on a correct counter -> q 0..7,0,1,2; synced=1 after the first edge; err=0; err_cnt=0; chk_cnt=10.
- load d=5, then en=1 up=0 for 7 cycles, then syn_clr=1 for 1 cycle -> q 5,4,..,0,7,6 then 0; err stays 0.
- Force q to 3 for one cycle where 2 is expected -> mismatch pulses 1 cycle later; err=1; err_cnt=1; first_exp=2; first_got=3. Subsequent correct cycles produce no further errors.
- STOP_ON_ERR=1: inject 2 mismatches 3 cycles apart -> err_cnt=1, chk_cnt frozen, mismatch high once. Then resync -> counting resumes with err_cnt still 1.
- syn_clr=1 and load=1 with d=6 in the same cycle -> expected 0; a counter giving 6 is flagged. rst mid-count -> all outputs 0 at the next cycle.
- TICK_CHECK_EN defined: hold max_tick low while q=7 -> err_cnt=1, first_got=7. Undefined: same stimulus -> err=0.
